// File: rtl/dat_pattern_gen.sv
// dat_pattern_gen: DAT-path stimulus generator. On start it latches a transfer
// configuration, writes word_cnt patterned words into the DAT Tx buffer (with
// tx_buf_full backpressure), holds DAT0 busy for busy_cycles, then pulses
// tx_data_init/done.
module dat_pattern_gen #(
  parameter int unsigned FIFO_WIDTH      = 32,
  parameter int unsigned WORD_CNT_WIDTH  = 8,
  parameter int unsigned BLOCK_SZ_WIDTH  = 12,
  parameter int unsigned BLOCK_CNT_WIDTH = 16,
  parameter int unsigned BUSY_CNT_WIDTH  = 8,
  parameter logic [FIFO_WIDTH-1:0] LFSR_TAPS = 32'h80200003
) (
  input  logic                       host_clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic [FIFO_WIDTH-1:0]      seed,
  input  logic [WORD_CNT_WIDTH-1:0]  word_cnt,
  input  logic [BUSY_CNT_WIDTH-1:0]  busy_cycles,
  input  logic [BLOCK_SZ_WIDTH-1:0]  cfg_block_sz,
  input  logic [BLOCK_CNT_WIDTH-1:0] cfg_block_cnt,
  input  logic                       tx_buf_full,
  output logic                       tx_buf_wr_host,
  output logic [FIFO_WIDTH-1:0]      tx_buf_din_out,
  output logic [BLOCK_SZ_WIDTH-1:0]  block_sz,
  output logic [BLOCK_CNT_WIDTH-1:0] block_cnt,
  output logic                       dat0_out,
  output logic                       tx_data_init,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    GAP,
    HOLD,
    INIT
  } state_t;

  state_t state;
  state_t next_state;

  logic [1:0]                mode_q;
  logic [WORD_CNT_WIDTH-1:0] words_left;
  logic [BUSY_CNT_WIDTH-1:0] busy_left;
  logic                      accept;
  logic                      last_word;

  logic wr_d;
  logic dat0_d;
  logic init_d;
  logic busy_d;

  // First word of a transfer: walking-one always starts at bit 0, and a zero
  // LFSR seed would lock up so it is replaced by 1.
  function automatic logic [FIFO_WIDTH-1:0] first_word(
    input logic [1:0]            m,
    input logic [FIFO_WIDTH-1:0] s
  );
    case (m)
      2'd1:    first_word = FIFO_WIDTH'(1);
      2'd2:    first_word = (s == '0) ? FIFO_WIDTH'(1) : s;
      default: first_word = s;
    endcase
  endfunction

  // Successor of word w in pattern m.
  function automatic logic [FIFO_WIDTH-1:0] next_word(
    input logic [1:0]            m,
    input logic [FIFO_WIDTH-1:0] w
  );
    case (m)
      2'd0:    next_word = w + FIFO_WIDTH'(1);
      2'd1:    next_word = {w[FIFO_WIDTH-2:0], w[FIFO_WIDTH-1]};
      2'd2:    next_word = {w[FIFO_WIDTH-2:0], ^(w & LFSR_TAPS)};
      default: next_word = w;
    endcase
  endfunction

  assign accept    = (state == FILL) && tx_buf_wr_host && !tx_buf_full;
  assign last_word = accept && (words_left == WORD_CNT_WIDTH'(1));

  // State register plus registered control outputs.
  // Outputs are decoded from next_state and registered, so they line up with
  // the state they describe while still coming straight from flops.
  always_ff @(posedge host_clk) begin
    if (rst) begin
      state          <= IDLE;
      tx_buf_wr_host <= 1'b0;
      dat0_out       <= 1'b1;
      tx_data_init   <= 1'b0;
      done           <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= next_state;
      tx_buf_wr_host <= wr_d;
      dat0_out       <= dat0_d;
      tx_data_init   <= init_d;
      done           <= init_d;
      busy           <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (word_cnt != '0)         next_state = FILL;
          else if (busy_cycles != '0) next_state = HOLD;
          else                        next_state = INIT;
        end
      end
      FILL: begin
        if (last_word) next_state = GAP;
      end
      GAP: begin
        if (busy_left != '0) next_state = HOLD;
        else                 next_state = INIT;
      end
      HOLD: begin
        if (busy_left == BUSY_CNT_WIDTH'(1)) next_state = INIT;
      end
      INIT: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode of the upcoming state.
  always_comb begin
    wr_d   = (next_state == FILL);
    dat0_d = (next_state != HOLD);
    init_d = (next_state == INIT);
    busy_d = (next_state != IDLE);
  end

  // Configuration latch, word/busy counters and pattern generation.
  always_ff @(posedge host_clk) begin
    if (rst) begin
      mode_q         <= '0;
      words_left     <= '0;
      busy_left      <= '0;
      tx_buf_din_out <= '0;
      block_sz       <= '0;
      block_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q         <= mode;
            words_left     <= word_cnt;
            busy_left      <= busy_cycles;
            block_sz       <= cfg_block_sz;
            block_cnt      <= cfg_block_cnt;
            tx_buf_din_out <= first_word(mode, seed);
          end
        end
        FILL: begin
          if (accept) begin
            words_left <= words_left - WORD_CNT_WIDTH'(1);
            if (!last_word) tx_buf_din_out <= next_word(mode_q, tx_buf_din_out);
          end
        end
        HOLD: begin
          busy_left <= busy_left - BUSY_CNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dat_pattern_gen.md
# dat_pattern_gen

Synthesizable, parametrised successor to the DAT-path stimulus. On a `start` pulse it latches a transfer configuration and pushes a programmable number of patterned words into the DAT Tx buffer with backpressure from `tx_buf_full`. It then holds the card-side DAT0 busy indication for a programmable number of cycles, pulses `tx_data_init`, and reports `done`. It sits between the host register file (or a bench) and the DAT block's Tx FIFO and init inputs.

## Interface
- `FIFO_WIDTH`, 32, Tx buffer word width
- `WORD_CNT_WIDTH`, 8, width of word-count config
- `BLOCK_SZ_WIDTH`, 12, width of block size
- `BLOCK_CNT_WIDTH`, 16, width of block count
- `BUSY_CNT_WIDTH`, 8, width of busy-duration config
- `LFSR_TAPS`, 32'h80200003, feedback tap mask for LFSR mode (bit i set = tap on bit i)

- `host_clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request; honoured only in IDLE
- `mode`  in  2  0 increment, 1 walking-one, 2 LFSR, 3 constant
- `seed`  in  FIFO_WIDTH  first word / LFSR seed / constant value
- `word_cnt`  in  WORD_CNT_WIDTH  number of words to write (0 = none)
- `busy_cycles`  in  BUSY_CNT_WIDTH  cycles DAT0 is held low (0 = skip)
- `cfg_block_sz`  in  BLOCK_SZ_WIDTH  block size to present to DAT
- `cfg_block_cnt`  in  BLOCK_CNT_WIDTH  block count to present to DAT
- `tx_buf_full`  in  1  Tx FIFO full; write not accepted while high
- `tx_buf_wr_host`  out  1  Tx FIFO write request (registered)
- `tx_buf_din_out`  out  FIFO_WIDTH  Tx FIFO write data (registered)
- `block_sz`  out  BLOCK_SZ_WIDTH  latched block size
- `block_cnt`  out  BLOCK_CNT_WIDTH  latched block count
- `dat0_out`  out  1  DAT0 level; 0 = card busy
- `tx_data_init`  out  1  one-cycle Tx init pulse to DAT
- `busy`  out  1  high whenever state != IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, FILL, GAP, HOLD, INIT.
- IDLE: on `start`, latch `mode`, `seed`, `word_cnt`, `busy_cycles`; `cfg_block_sz` goes to `block_sz`; `cfg_block_cnt` goes to `block_cnt`. Next state is FILL if `word_cnt`≠0, else HOLD if `busy_cycles`≠0, else INIT.
- FILL: `tx_buf_wr_host`=1 with the current word on `tx_buf_din_out`.
  - A word is accepted on an edge where `tx_buf_wr_host`=1 and `tx_buf_full`=0. Only then does the index advance.
  - While full, both write strobe and data hold unchanged.
  - After the `word_cnt`-th acceptance, go to GAP.
- GAP: one cycle, `tx_buf_wr_host`=0. Next state is HOLD if `busy_cycles`≠0, else INIT.
- HOLD: `dat0_out`=0 for exactly `busy_cycles` cycles, then INIT.
- INIT: `tx_data_init`=1 and `done`=1 for one cycle, then IDLE.
- Patterns, with word index i from 0 and modulo-2^FIFO_WIDTH arithmetic:
  - increment: `seed`+i
  - walking-one: 1 << (i mod FIFO_WIDTH)
  - LFSR: word0=`seed`; next = {w[W-2:0], ^(w & LFSR_TAPS)}. A zero seed is replaced by 1.
  - constant: `seed` for every word.
- `start` outside IDLE is ignored. Config inputs are don't-care after latching.
- `block_sz`/`block_cnt` hold their latched values until the next accepted `start` or reset.

## Timing
- Reset values: `tx_buf_wr_host`=0, `tx_buf_din_out`=0, `block_sz`=0, `block_cnt`=0, `dat0_out`=1, `tx_data_init`=0, `busy`=0, `done`=0; state IDLE.
- `rst` asserted mid-operation aborts on the next edge to reset values. A partially filled FIFO is not rolled back.
- `start` sampled at edge k: from edge k+1, `busy`=1 and (if `word_cnt`≠0) `tx_buf_wr_host`=1 with word0.
- With no backpressure, N words occupy N consecutive cycles. Each cycle of `tx_buf_full` adds one cycle.
- `tx_data_init` is never asserted while `tx_buf_wr_host`=1 or `dat0_out`=0.
- Total latency with no backpressure, `start` to `done`: 1 + N + (N>0) + B + 1 cycles.
- `done` and `busy` fall together: `busy`=0 on the cycle after `done`.

## Test plan
- Mode 0, seed 32'h1234ABCD, `word_cnt`=16, `busy_cycles`=0, full never high -> 16 consecutive writes 32'h1234ABCD..32'h1234ABDC. One GAP cycle, then `tx_data_init`/`done` on cycle 19 after `start`.
- Same as above with `tx_buf_full` high for cycles 3–5 of FILL -> word2 held for 3 extra cycles, no word skipped or duplicated, 16 total acceptances.
- Mode 1, `word_cnt`=34, W=32 -> words 1,2,4,…,32'h80000000,1,2. Mode 2, seed 0 -> first word 1.
- `word_cnt`=0, `busy_cycles`=5, `cfg_block_sz`=64, `cfg_block_cnt`=10 -> no writes; `dat0_out` low exactly 5 cycles; `block_sz`=64, `block_cnt`=10; `tx_data_init` on the following cycle.
- Second `start` during FILL ignored. `rst` asserted mid-HOLD -> next edge `dat0_out`=1, `busy`=0, no `tx_data_init`; a new `start` then runs normally.
